lfsr_rr_server: RTL and testbench
=================================

# lfsr_rr_server

Round-robin server that shares one 4-bit PRBS generator (x^4+x+1, period 15, seed 4'b0001) among NREQ requesters. A granted requester receives one WORD_W-bit pseudo-random word, shifted out serially from the LFSR and delivered with a one-cycle valid pulse. The block also owns seeding of the generator. It sits between the test-pattern/scrambler clients and the PRBS source.

## Interface
- NREQ, 4, number of requesters (2..8)
- WORD_W, 8, bits per delivered word (1..32)
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- seed_load  in  1  load `seed` into the LFSR (honoured only in IDLE)
- seed  in  4  seed value; 4'b0000 is replaced by 4'b0001
- req  in  NREQ  per-requester request level
- gnt  out  NREQ  one-hot grant, held for the whole service
- rdata  out  WORD_W  last delivered word, first-generated bit in MSB
- rvalid  out  1  one-cycle pulse: rdata valid for the granted requester
- busy  out  1  high in GEN and DONE

## Operation
- LFSR state S, 4 bits. Step: S'[0]=S[3], S'[1]=S[0]^S[3], S'[3:2]=S[2:1]. Output bit of a step is S[3] before the step.
- The LFSR advances only in GEN. It never advances in IDLE or DONE.
- Internal registers: FSM state, S, shift register sh[WORD_W-1:0], step counter cnt, round-robin pointer ptr, registered gnt/rdata/rvalid.
- Reset values: state IDLE, S=4'b0001, ptr=0, cnt=0, sh=0, gnt=0, rdata=0, rvalid=0, busy=0.
- IDLE:
  - seed_load=1: S <= (seed==0 ? 4'b0001 : seed). Stay in IDLE. Requests are not granted this cycle, so seed_load has priority.
  - Otherwise, if req!=0: grant the first set req bit at or after ptr, wrapping modulo NREQ. Set gnt one-hot, cnt=0, go to GEN.
- GEN, each cycle:
  - sh <= {sh[WORD_W-2:0], S[3]}
  - S <= S'
  - cnt++
  - When cnt==WORD_W-1, go to DONE and load rdata with the completed shift value.
- DONE, one cycle:
  - rvalid=1, gnt held.
  - ptr <= granted index + 1 (mod NREQ).
  - Next state IDLE. gnt clears on the IDLE entry.
- Requests:
  - Deasserting req during GEN/DONE does not abort; the word is still delivered and ptr still advances.
  - Requesters hold req while they need service.
- seed_load in GEN or DONE is ignored; it is not queued.
- rdata holds its value until the next DONE.
- Reset mid-service: all registers return to reset values immediately. The partial word is discarded and rvalid is not issued.

## Timing
- req sampled in IDLE at edge T: gnt high from T. The WORD_W shifts occur at edges T+1..T+WORD_W. rvalid and the new rdata are high during the cycle after edge T+WORD_W. gnt falls at edge T+WORD_W+1.
- Service occupancy is WORD_W+1 cycles in GEN/DONE plus a mandatory IDLE cycle. Back-to-back grants are therefore spaced WORD_W+2 cycles apart.
- Seed load takes effect one edge after sampling. A grant can be issued in the following IDLE cycle at the earliest.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then hold req=4'b0001 (WORD_W=8) -> gnt=0001 and rvalid pulses with rdata=8'h13. The following grant yields rdata=8'h5E, and S returns to 4'b0001 after 15 total steps.
- req=4'b1111 held continuously -> grants in order 0001, 0010, 0100, 1000, 0001. Grant spacing is 10 cycles, and exactly one rvalid is issued per grant.
- Stream of 15 words (WORD_W=1) from reset -> rdata bits 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1, then the sequence repeats.
- seed_load with seed=0 while req=4'b0010 -> no grant that cycle, S=4'b0001, grant on the next cycle. seed_load with seed=4'b1000 during GEN -> ignored and the word is unchanged.
- Drop req[2] mid-GEN with ptr=2 -> word still delivered, rvalid pulses, and the next grant goes to the first set bit at or after index 3.
- Assert rstn=0 at cnt=4 -> gnt, rvalid, rdata and busy read 0 immediately, and S=0001. The next word after reset equals 8'h13.

Source files
------------

// File: rtl/lfsr_rr_server.sv
// Round-robin server sharing one x^4+x+1 PRBS generator among NREQ requesters.
// Each grant shifts WORD_W LFSR bits into a word delivered with a one-cycle rvalid pulse.
module lfsr_rr_server #(
    parameter int NREQ   = 4,
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              seed_load,
    input  logic [3:0]        seed,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    output logic [WORD_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [3:0]          s;
    logic [WORD_W-1:0]   sh;
    logic [CNT_W-1:0]    cnt;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    gidx;

    logic [3:0]          s_next;
    logic [WORD_W:0]     sh_ext;
    logic [WORD_W-1:0]   sh_next;
    logic                pick_found;
    logic [PTR_W-1:0]    pick_idx;
    int unsigned         idx;

    assign dbg_state = state;

    assign s_next  = {s[2:1], s[0] ^ s[3], s[3]};
    assign sh_ext  = {sh, s[3]};
    assign sh_next = sh_ext[WORD_W-1:0];

    // Handshake: req is a level held by the requester; the server answers with
    // gnt held for the whole service and rvalid high for exactly one cycle.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            s      <= 4'b0001;
            sh     <= '0;
            cnt    <= '0;
            ptr    <= '0;
            gidx   <= '0;
            gnt    <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Seeding wins over granting in the same cycle.
                    if (seed_load) begin
                        s <= (seed == 4'b0000) ? 4'b0001 : seed;
                    end else if (pick_found) begin
                        gidx  <= pick_idx;
                        gnt   <= NREQ'(1) << pick_idx;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= GEN;
                    end
                end
                GEN: begin
                    sh  <= sh_next;
                    s   <= s_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WORD_W - 1)) begin
                        rdata  <= sh_next;
                        rvalid <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    rvalid <= 1'b0;
                    gnt    <= '0;
                    busy   <= 1'b0;
                    ptr    <= (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rr_server.sv
// Bench for lfsr_rr_server: directed scenarios plus random traffic, checked
// against a sequence-position model of the PRBS and a cycle-count service model.
module tb_lfsr_rr_server;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic            clk = 1'b0;
    logic            rstn;
    logic            seed_load;
    logic [3:0]      seed;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [W-1:0]    rdata;
    logic            rvalid;
    logic            busy;
    logic [1:0]      dbg_state;

    lfsr_rr_server #(.NREQ(NREQ), .WORD_W(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .seed_load (seed_load),
        .seed      (seed),
        .req       (req),
        .gnt       (gnt),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0]    exp_q[$];
    logic [NREQ-1:0] exp_gnt_q[$];

    // Ring of the 15 generator states starting from 4'b0001.
    logic [3:0]  ring[15];
    int          m_pos, m_ptr, m_rem, m_win;
    logic [W-1:0] m_word, m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        ring[0] = 4'b0001;
        for (int k = 1; k < 15; k++)
            ring[k] = {ring[k-1][2:1], ring[k-1][0] ^ ring[k-1][3], ring[k-1][3]};
    end

    // Reference model: a service lasts W+1 edges after the grant edge, the word is
    // the next W output bits of the ring, and the pointer moves past the winner.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pos = 0; m_ptr = 0; m_rem = 0; m_win = 0;
            m_word = '0; m_last = '0;
            exp_q.delete();
            exp_gnt_q.delete();
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 1) m_last = m_word;
            if (m_rem == 0) m_ptr = (m_win + 1) % NREQ;
        end else if (seed_load) begin
            for (int k = 0; k < 15; k++)
                if (ring[k] == ((seed == 4'd0) ? 4'd1 : seed)) m_pos = k;
        end else if (req != '0) begin
            for (int i = NREQ - 1; i >= 0; i--)
                if (req[(m_ptr + i) % NREQ]) m_win = (m_ptr + i) % NREQ;
            m_word = '0;
            for (int k = 0; k < W; k++)
                m_word = {m_word[W-2:0], ring[(m_pos + k) % 15][3]};
            m_pos = (m_pos + W) % 15;
            m_rem = W + 1;
            exp_q.push_back(m_word);
            exp_gnt_q.push_back(NREQ'(1) << m_win);
        end
    end

    // Monitor: per-cycle output checks plus scoreboard pop on each rvalid.
    always @(negedge clk) begin
        if (rstn) begin
            chk("busy", busy, (m_rem > 0));
            chk("rvalid", rvalid, (m_rem == 1));
            chk("gnt", gnt, (m_rem > 0) ? (32'd1 << m_win) : 32'd0);
            chk("rdata_hold", rdata, m_last);
            if (rvalid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rvalid", 1, 0);
                end else begin
                    chk("word", rdata, exp_q.pop_front());
                    chk("word_gnt", gnt, exp_gnt_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rvalid(input int budget);
        int n = 0;
        while (!rvalid && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid) chk("rvalid_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
    endtask

    logic [NREQ-1:0] rr_exp[5];
    realtime t_prev;

    initial begin
        rstn = 1'b0; req = '0; seed_load = 1'b0; seed = '0;
        tick(3);
        chk("reset_gnt", gnt, 0);
        chk("reset_rvalid", rvalid, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_busy", busy, 0);
        rstn = 1'b1;
        tick(1);

        // Two words for requester 0 from reset.
        req = 4'b0001;
        wait_rvalid(40);
        chk("first_word", rdata, 8'h13);
        tick(1);
        wait_rvalid(40);
        chk("second_word", rdata, 8'h5E);
        tick(1);
        req = '0;
        tick(3);

        // All requesting: strict rotation from reset with fixed spacing.
        do_reset();
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        req = 4'b1111;
        t_prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_rvalid(40);
            chk("rr_order", gnt, rr_exp[g]);
            if (g > 0) chk("rr_spacing", int'(($realtime - t_prev) / 10.0), W + 2);
            t_prev = $realtime;
            tick(1);
        end

        // Grant to 1 moves ptr to 2; drop req[2] during its GEN.
        wait_rvalid(40);
        chk("pre_drop_gnt", gnt, 4'b0010);
        tick(3);
        chk("drop_gnt_active", gnt, 4'b0100);
        req = 4'b1001;
        wait_rvalid(40);
        chk("drop_word_gnt", gnt, 4'b0100);
        tick(1);
        wait_rvalid(40);
        chk("after_drop_gnt", gnt, 4'b1000);
        tick(1);
        req = '0;
        tick(4);

        // Zero seed with a pending request: seed wins, grant next cycle.
        req = 4'b0010; seed_load = 1'b1; seed = 4'b0000;
        tick(1);
        seed_load = 1'b0;
        chk("seed_no_grant", gnt, 0);
        tick(1);
        chk("seed_then_grant", gnt, 4'b0010);
        tick(2);
        seed_load = 1'b1; seed = 4'b1000;
        tick(1);
        seed_load = 1'b0;
        wait_rvalid(40);
        chk("seed_zero_word", rdata, 8'h13);
        tick(1);
        req = '0;
        tick(3);

        // Nonzero seed in IDLE.
        seed_load = 1'b1; seed = 4'b1000;
        tick(1);
        seed_load = 1'b0; req = 4'b0001;
        wait_rvalid(40);
        tick(1);
        req = '0;
        tick(3);

        // Reset in the middle of a service at cnt=4.
        req = 4'b0001;
        tick(1);
        tick(4);
        rstn = 1'b0;
        #1;
        chk("midrst_gnt", gnt, 0);
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_rdata", rdata, 0);
        chk("midrst_busy", busy, 0);
        tick(1);
        rstn = 1'b1;
        wait_rvalid(40);
        chk("post_reset_word", rdata, 8'h13);
        tick(1);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            req       = NREQ'($urandom_range(0, 15));
            seed_load = ($urandom_range(0, 9) == 0);
            seed      = 4'($urandom_range(0, 15));
            tick(1);
        end
        req = '0; seed_load = 1'b0;
        tick(20);
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
